// File: rtl/perceptron_pkg.sv
// Shared widths, class encodings and FSM states
// for the perceptron inference datapath.
package perceptron_pkg;

  localparam int X_W    = 7;
  localparam int W_W    = 14;
  localparam int M_W    = 18;
  localparam int P_W    = 25;
  localparam int YIN_W  = 26;
  localparam int W_FRAC = 4;
  localparam int B_FRAC = 8;
  localparam int MUL_CYC = 7;
  localparam int CNT_W  = 8;

  localparam logic [1:0] CLASS_POS = 2'b01;
  localparam logic [1:0] CLASS_NEG = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL1,
    S_MUL2,
    S_SUM,
    S_OUT
  } state_e;

  function automatic logic [1:0] class_of(
    input logic signed [YIN_W-1:0] y
  );
    return y[YIN_W-1] ? CLASS_NEG : CLASS_POS;
  endfunction

endpackage

// File: rtl/serial_mult7x18.sv
// Signed 7x18 shift-add multiplier, magnitude form,
// LSB first, one partial product per cycle.
module serial_mult7x18
  import perceptron_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic signed [X_W-1:0] x_i,
  input  logic signed [M_W-1:0] m_i,
  output logic                  done_o,
  output logic signed [P_W-1:0] prod_o
);

  logic [X_W-1:0]        mag_q, mag_d, mag_s;
  logic signed [P_W-1:0] mc_q, mc_d, mc_s;
  logic signed [P_W-1:0] acc_q, acc_d, acc_s;
  logic signed [P_W-1:0] prod_q, prod_d;
  logic signed [P_W-1:0] sum_s;
  logic                  neg_q, neg_d, neg_s;
  logic                  busy_q, busy_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  last_s;

  // The start cycle performs iteration 0 straight off the ports.
  always_comb begin
    mag_s = mag_q;
    mc_s  = mc_q;
    acc_s = acc_q;
    neg_s = neg_q;
    if (start_i) begin
      mag_s = x_i[X_W-1] ? (~x_i + 7'd1) : x_i;
      mc_s  = {{(P_W-M_W){m_i[M_W-1]}}, m_i};
      acc_s = '0;
      neg_s = x_i[X_W-1];
    end
  end

  assign sum_s  = mag_s[0] ? (acc_s + mc_s) : acc_s;
  assign last_s = busy_q && (cnt_q == 3'(MUL_CYC-1));

  always_comb begin
    mag_d  = mag_q;
    mc_d   = mc_q;
    acc_d  = acc_q;
    neg_d  = neg_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;
    prod_d = prod_q;
    if (start_i) begin
      mag_d  = mag_s >> 1;
      mc_d   = mc_s <<< 1;
      acc_d  = sum_s;
      neg_d  = neg_s;
      busy_d = 1'b1;
      cnt_d  = 3'd1;
    end else if (busy_q) begin
      mag_d = mag_s >> 1;
      mc_d  = mc_s <<< 1;
      acc_d = sum_s;
      cnt_d = cnt_q + 3'd1;
      if (last_s) begin
        busy_d = 1'b0;
        prod_d = neg_q ? -sum_s : sum_s;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mag_q  <= '0;
      mc_q   <= '0;
      acc_q  <= '0;
      neg_q  <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
      prod_q <= '0;
    end else begin
      mag_q  <= mag_d;
      mc_q   <= mc_d;
      acc_q  <= acc_d;
      neg_q  <= neg_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      prod_q <= prod_d;
    end
  end

  assign done_o = last_s;
  assign prod_o = prod_q;

endmodule

// File: rtl/perceptron_classifier.sv
// Classifies (X1, X2) samples with latched perceptron
// weights through one shared serial multiplier.
module perceptron_classifier
  import perceptron_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    loadWeights,
  input  logic signed [W_W-1:0]   W1In,
  input  logic signed [W_W-1:0]   W2In,
  input  logic signed [W_W-1:0]   BiasIn,
  input  logic                    inValid,
  output logic                    inReady,
  input  logic signed [X_W-1:0]   X1In,
  input  logic signed [X_W-1:0]   X2In,
  output logic                    outValid,
  input  logic                    outReady,
  output logic [1:0]              yClass,
  output logic signed [YIN_W-1:0] yin,
  output logic [CNT_W-1:0]        sampleCount,
  output logic                    weightsLoaded
);

  state_e                  state_q;
  logic signed [W_W-1:0]   w1_q, w2_q, bias_q;
  logic signed [X_W-1:0]   x1_q, x2_q;
  logic signed [P_W-1:0]   p1_q;
  logic signed [YIN_W-1:0] yin_q, yin_d;
  logic [1:0]              ycls_q;
  logic                    outv_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    wl_q;
  logic                    first_q;

  logic                    mul_start;
  logic                    mul_done;
  logic signed [X_W-1:0]   mul_x;
  logic signed [W_W-1:0]   mul_w;
  logic signed [M_W-1:0]   mul_m;
  logic signed [P_W-1:0]   mul_prod;
  logic                    in_fire;

  assign inReady = (state_q == S_IDLE) && wl_q;
  assign in_fire = inValid && inReady;

  // Weights are read on the start edge, so a same-edge load is seen.
  assign mul_start = first_q &&
                     ((state_q == S_MUL1) || (state_q == S_MUL2));
  assign mul_x = (state_q == S_MUL2) ? x2_q : x1_q;
  assign mul_w = (state_q == S_MUL2) ? w2_q : w1_q;
  assign mul_m = {mul_w, {W_FRAC{1'b0}}};

  serial_mult7x18 u_mult (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (mul_start),
    .x_i     (mul_x),
    .m_i     (mul_m),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  assign yin_d = {{(YIN_W-P_W){p1_q[P_W-1]}}, p1_q}
               + {{(YIN_W-P_W){mul_prod[P_W-1]}}, mul_prod}
               + {{(YIN_W-W_W){bias_q[W_W-1]}}, bias_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      w1_q    <= '0;
      w2_q    <= '0;
      bias_q  <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      p1_q    <= '0;
      yin_q   <= '0;
      ycls_q  <= CLASS_POS;
      outv_q  <= 1'b0;
      cnt_q   <= '0;
      wl_q    <= 1'b0;
      first_q <= 1'b0;
    end else begin
      first_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (loadWeights) begin
            w1_q   <= W1In;
            w2_q   <= W2In;
            bias_q <= BiasIn;
            wl_q   <= 1'b1;
          end
          if (in_fire) begin
            x1_q    <= X1In;
            x2_q    <= X2In;
            first_q <= 1'b1;
            state_q <= S_MUL1;
          end
        end
        S_MUL1: begin
          if (mul_done) begin
            first_q <= 1'b1;
            state_q <= S_MUL2;
          end
        end
        S_MUL2: begin
          if (first_q) p1_q <= mul_prod;
          if (mul_done) state_q <= S_SUM;
        end
        S_SUM: begin
          yin_q   <= yin_d;
          ycls_q  <= class_of(yin_d);
          outv_q  <= 1'b1;
          state_q <= S_OUT;
        end
        S_OUT: begin
          if (outReady) begin
            outv_q  <= 1'b0;
            cnt_q   <= cnt_q + 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign outValid      = outv_q;
  assign yClass        = ycls_q;
  assign yin           = yin_q;
  assign sampleCount   = cnt_q;
  assign weightsLoaded = wl_q;

endmodule

// File: tb/tb_perceptron_classifier.sv
// Randomized scenario bench for perceptron_classifier
// against an integer-arithmetic reference model.
module tb_perceptron_classifier;

  logic               clk = 1'b0;
  logic               rst;
  logic               loadWeights;
  logic signed [13:0] W1In, W2In, BiasIn;
  logic               inValid, inReady;
  logic signed [6:0]  X1In, X2In;
  logic               outValid, outReady;
  logic [1:0]         yClass;
  logic signed [25:0] yin;
  logic [7:0]         sampleCount;
  logic               weightsLoaded;

  int n_checks = 0;
  int n_fail   = 0;
  int mw1, mw2, mb;
  int mcount;

  always #5 clk = ~clk;

  perceptron_classifier dut (
    .clk           (clk),
    .rst           (rst),
    .loadWeights   (loadWeights),
    .W1In          (W1In),
    .W2In          (W2In),
    .BiasIn        (BiasIn),
    .inValid       (inValid),
    .inReady       (inReady),
    .X1In          (X1In),
    .X2In          (X2In),
    .outValid      (outValid),
    .outReady      (outReady),
    .yClass        (yClass),
    .yin           (yin),
    .sampleCount   (sampleCount),
    .weightsLoaded (weightsLoaded)
  );

  function automatic int ref_yin(int x1, int x2);
    return x1 * (mw1 * 16) + x2 * (mw2 * 16) + mb;
  endfunction

  function automatic logic [1:0] ref_cls(int y);
    return (y < 0) ? 2'b11 : 2'b01;
  endfunction

  function automatic int rnd_w();
    return int'($urandom_range(16383)) - 8192;
  endfunction

  function automatic int rnd_x();
    return int'($urandom_range(127)) - 64;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_w(int w1, int w2, int b);
    W1In = 14'(w1);
    W2In = 14'(w2);
    BiasIn = 14'(b);
    loadWeights = 1'b1;
    tick();
    loadWeights = 1'b0;
    mw1 = w1;
    mw2 = w2;
    mb = b;
  endtask

  task automatic do_sample(int x1, int x2, output int lat,
                           output logic signed [25:0] y,
                           output logic [1:0] c);
    int w;
    w = 0;
    X1In = 7'(x1);
    X2In = 7'(x2);
    inValid = 1'b1;
    while (!inReady && w < 50) begin
      tick();
      w++;
    end
    tick();
    inValid = 1'b0;
    lat = 0;
    while (!outValid && lat < 50) begin
      tick();
      lat++;
    end
    y = yin;
    c = yClass;
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    if (lat < 50) mcount = (mcount + 1) % 256;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    mcount = 0;
    n_checks++;
    if (outValid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outValid got %b want 0", outValid);
    end
    n_checks++;
    if (inReady !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_inReady got %b want 0", inReady);
    end
    n_checks++;
    if (yClass !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_yClass got %b want 01", yClass);
    end
    n_checks++;
    if (yin !== 26'sd0) begin
      n_fail++;
      $display("FAIL reset_yin got %0d want 0", yin);
    end
    n_checks++;
    if (sampleCount !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_count got %0d want 0", sampleCount);
    end
    n_checks++;
    if (weightsLoaded !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wl got %b want 0", weightsLoaded);
    end
  endtask

  task automatic test_no_weights();
    X1In = 7'(rnd_x());
    X2In = 7'(rnd_x());
    inValid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) inValid = 1'b0;
      tick();
      n_checks++;
      if ({inReady, outValid} !== 2'b00) begin
        n_fail++;
        $display("FAIL noweights_cyc%0d inReady/outValid got %b want 00",
                 i, {inReady, outValid});
      end
    end
    n_checks++;
    if (weightsLoaded !== 1'b0) begin
      n_fail++;
      $display("FAIL noweights_wl got %b want 0", weightsLoaded);
    end
  endtask

  task automatic test_basic();
    int lat;
    logic signed [25:0] y;
    logic [1:0] c;
    load_w(16, -32, 0);
    n_checks++;
    if ({weightsLoaded, inReady} !== 2'b11) begin
      n_fail++;
      $display("FAIL basic_loaded got %b want 11",
               {weightsLoaded, inReady});
    end
    do_sample(3, 1, lat, y, c);
    n_checks++;
    if (lat !== 15) begin
      n_fail++;
      $display("FAIL basic_latency got %0d want 15", lat);
    end
    n_checks++;
    if (y !== 26'sd256) begin
      n_fail++;
      $display("FAIL basic_yin got %0d want 256", y);
    end
    n_checks++;
    if (c !== 2'b01) begin
      n_fail++;
      $display("FAIL basic_class got %b want 01", c);
    end
    n_checks++;
    if ({sampleCount, inReady} !== {8'(mcount), 1'b1}) begin
      n_fail++;
      $display("FAIL basic_after count=%0d ready=%b want %0d 1",
               sampleCount, inReady, mcount);
    end
  endtask

  task automatic test_extremes();
    int lat;
    logic signed [25:0] y;
    logic [1:0] c;
    load_w(-8192, -8192, -8192);
    do_sample(-64, -64, lat, y, c);
    n_checks++;
    if ({y, c} !== {26'sd16769024, 2'b01}) begin
      n_fail++;
      $display("FAIL ext_max got %0d/%b want 16769024/01", y, c);
    end
    load_w(8191, 1234, 2048);
    do_sample(-64, 0, lat, y, c);
    n_checks++;
    if ({y, c} !== {-26'sd8385536, 2'b11}) begin
      n_fail++;
      $display("FAIL ext_min got %0d/%b want -8385536/11", y, c);
    end
  endtask

  task automatic test_zero();
    int lat;
    logic signed [25:0] y;
    logic [1:0] c;
    load_w(0, 0, 0);
    do_sample(0, 0, lat, y, c);
    n_checks++;
    if ({y, c} !== {26'sd0, 2'b01}) begin
      n_fail++;
      $display("FAIL zero got %0d/%b want 0/01", y, c);
    end
    n_checks++;
    if (lat !== 15) begin
      n_fail++;
      $display("FAIL zero_latency got %0d want 15", lat);
    end
  endtask

  task automatic test_backpressure();
    int x1, x2, e, w;
    logic signed [25:0] y0;
    logic [1:0] c0;
    load_w(rnd_w(), rnd_w(), rnd_w());
    x1 = rnd_x();
    x2 = rnd_x();
    e = ref_yin(x1, x2);
    X1In = 7'(x1);
    X2In = 7'(x2);
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    w = 0;
    while (!outValid && w < 50) begin
      tick();
      w++;
    end
    y0 = yin;
    c0 = yClass;
    n_checks++;
    if ({y0, c0} !== {26'(e), ref_cls(e)}) begin
      n_fail++;
      $display("FAIL bp_result got %0d/%b want %0d/%b",
               y0, c0, e, ref_cls(e));
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({outValid, yin, yClass, inReady} !==
          {1'b1, 26'(e), ref_cls(e), 1'b0}) begin
        n_fail++;
        $display("FAIL bp_hold%0d v=%b y=%0d c=%b rdy=%b want 1 %0d %b 0",
                 i, outValid, yin, yClass, inReady, e, ref_cls(e));
      end
    end
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    mcount = (mcount + 1) % 256;
    n_checks++;
    if ({sampleCount, outValid, inReady} !== {8'(mcount), 2'b01}) begin
      n_fail++;
      $display("FAIL bp_release count=%0d v=%b rdy=%b want %0d 0 1",
               sampleCount, outValid, inReady, mcount);
    end
    tick();
    n_checks++;
    if (sampleCount !== 8'(mcount)) begin
      n_fail++;
      $display("FAIL bp_single count=%0d want %0d", sampleCount, mcount);
    end
  endtask

  task automatic test_load_with_accept();
    int e, w;
    load_w(0, 5, 100);
    W1In = 14'sd16;
    W2In = 14'sd5;
    BiasIn = 14'sd100;
    X1In = 7'sd7;
    X2In = 7'sd3;
    loadWeights = 1'b1;
    inValid = 1'b1;
    tick();
    loadWeights = 1'b0;
    inValid = 1'b0;
    mw1 = 16;
    e = ref_yin(7, 3);
    w = 0;
    while (!outValid && w < 50) begin
      tick();
      w++;
    end
    n_checks++;
    if (yin !== 26'(e)) begin
      n_fail++;
      $display("FAIL load_same_edge got %0d want %0d", yin, e);
    end
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    mcount = (mcount + 1) % 256;
    X1In = -7'sd5;
    X2In = 7'sd9;
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    W1In = -14'sd100;
    W2In = 14'sd77;
    BiasIn = -14'sd3;
    loadWeights = 1'b1;
    tick();
    loadWeights = 1'b0;
    e = ref_yin(-5, 9);
    w = 0;
    while (!outValid && w < 50) begin
      tick();
      w++;
    end
    n_checks++;
    if (yin !== 26'(e)) begin
      n_fail++;
      $display("FAIL load_in_mul1 got %0d want %0d", yin, e);
    end
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    mcount = (mcount + 1) % 256;
  endtask

  task automatic test_random();
    int lat, x1, x2, e;
    logic signed [25:0] y;
    logic [1:0] c;
    for (int i = 0; i < 12; i++) begin
      load_w(rnd_w(), rnd_w(), rnd_w());
      x1 = rnd_x();
      x2 = rnd_x();
      e = ref_yin(x1, x2);
      do_sample(x1, x2, lat, y, c);
      n_checks++;
      if ({y, c} !== {26'(e), ref_cls(e)}) begin
        n_fail++;
        $display("FAIL rand%0d x=%0d,%0d got %0d/%b want %0d/%b",
                 i, x1, x2, y, c, e, ref_cls(e));
      end
      n_checks++;
      if (lat !== 15) begin
        n_fail++;
        $display("FAIL rand%0d_latency got %0d want 15", i, lat);
      end
      n_checks++;
      if (sampleCount !== 8'(mcount)) begin
        n_fail++;
        $display("FAIL rand%0d_count got %0d want %0d",
                 i, sampleCount, mcount);
      end
    end
  endtask

  task automatic test_reset_mid();
    load_w(rnd_w(), rnd_w(), rnd_w());
    X1In = 7'(rnd_x());
    X2In = 7'(rnd_x());
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mcount = 0;
    n_checks++;
    if ({outValid, weightsLoaded, inReady, sampleCount} !== 11'd0) begin
      n_fail++;
      $display("FAIL rstmid v=%b wl=%b rdy=%b cnt=%0d want 0 0 0 0",
               outValid, weightsLoaded, inReady, sampleCount);
    end
    n_checks++;
    if ({yin, yClass} !== {26'sd0, 2'b01}) begin
      n_fail++;
      $display("FAIL rstmid_out got %0d/%b want 0/01", yin, yClass);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (outValid !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_discard cyc%0d outValid got %b want 0",
                 i, outValid);
      end
    end
  endtask

  task automatic test_back_to_back();
    int expq[$];
    int sent, got, cyc, e, x1, x2;
    logic acc;
    load_w(rnd_w(), rnd_w(), rnd_w());
    sent = 0;
    got = 0;
    cyc = 0;
    x1 = rnd_x();
    x2 = rnd_x();
    X1In = 7'(x1);
    X2In = 7'(x2);
    inValid = 1'b1;
    outReady = 1'b1;
    while (got < 256 && cyc < 6000) begin
      if (outValid) begin
        e = (expq.size() > 0) ? expq.pop_front() : 0;
        n_checks++;
        if ({yin, yClass} !== {26'(e), ref_cls(e)}) begin
          n_fail++;
          $display("FAIL b2b%0d got %0d/%b want %0d/%b",
                   got, yin, yClass, e, ref_cls(e));
        end
        got++;
      end
      acc = inValid && inReady;
      if (acc) expq.push_back(ref_yin(x1, x2));
      tick();
      cyc++;
      if (acc) begin
        sent++;
        x1 = rnd_x();
        x2 = rnd_x();
        X1In = 7'(x1);
        X2In = 7'(x2);
        if (sent == 256) inValid = 1'b0;
      end
    end
    outReady = 1'b0;
    inValid = 1'b0;
    n_checks++;
    if (got !== 256) begin
      n_fail++;
      $display("FAIL b2b_done got %0d results want 256", got);
    end
    n_checks++;
    if (sampleCount !== 8'd0) begin
      n_fail++;
      $display("FAIL b2b_wrap count got %0d want 0", sampleCount);
    end
  endtask

  initial begin
    rst = 1'b1;
    loadWeights = 1'b0;
    W1In = '0;
    W2In = '0;
    BiasIn = '0;
    inValid = 1'b0;
    X1In = '0;
    X2In = '0;
    outReady = 1'b0;
    test_reset();
    test_no_weights();
    test_basic();
    test_extremes();
    test_zero();
    test_backpressure();
    test_load_with_accept();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
